// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the FIFO burst reader.
// Read-domain consumer of the async FIFO.
package definitions;

  localparam int RD_DSIZE = 8;
  localparam int RD_LSIZE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus outgoing valid/ready stream.
// master = reader side, slave = FIFO/sink side.
interface fifo_burst_reader_if
  import definitions::*;
#(
  parameter int DSIZE = RD_DSIZE
);

  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;

  modport master (
    input  rdata,
    input  rempty,
    output rinc,
    output dout,
    output dout_valid,
    input  dout_ready,
    output dout_last
  );

  modport slave (
    output rdata,
    output rempty,
    input  rinc,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  dout_last
  );

endinterface

// File: rtl/fifo_burst_reader_rd_out_reg.sv
// One-entry output holding register for the stream.
// free tells the reader a new word may be loaded.
module rd_out_reg
  import definitions::*;
#(
  parameter int DSIZE = RD_DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] din,
  input  logic             last_in,
  input  logic             ready,
  output logic [DSIZE-1:0] dout,
  output logic             valid,
  output logic             last,
  output logic             free
);

  assign free = !valid || ready;

  // Load a word, or retire the held one on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
      last  <= last_in;
    end else if (ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops len words from the FIFO
// onto a registered valid/ready stream.
module fifo_burst_reader
  import definitions::*;
#(
  parameter int DSIZE = RD_DSIZE,
  parameter int LSIZE = RD_LSIZE
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             start,
  input  logic [LSIZE-1:0] len,
  input  logic             abort,
  fifo_burst_reader_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [LSIZE-1:0] xfer_cnt
);

  rd_state_t        state;
  rd_state_t        state_n;
  logic [LSIZE-1:0] remaining;
  logic             pop;
  logic             free;
  logic             is_last;
  logic             accept;

  assign is_last = (remaining == LSIZE'(1));
  assign accept  = (state == IDLE) && start
                && (len != '0);
  assign pop = (state == XFER) && !bus.rempty
            && (remaining != '0) && free
            && !abort;
  assign bus.rinc = pop;

  rd_out_reg #(
    .DSIZE(DSIZE)
  ) u_out (
    .clk    (rclk),
    .rst_n  (rrst_n),
    .load   (pop),
    .din    (bus.rdata),
    .last_in(is_last),
    .ready  (bus.dout_ready),
    .dout   (bus.dout),
    .valid  (bus.dout_valid),
    .last   (bus.dout_last),
    .free   (free)
  );

  // State register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == DONE);
    unique case (state)
      IDLE: begin
        if (accept) state_n = XFER;
      end
      XFER: begin
        if (abort) state_n = DRAIN;
        else if (pop && is_last) state_n = DRAIN;
      end
      DRAIN: begin
        if (!bus.dout_valid || bus.dout_ready)
          state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Words left to pop and words popped so far.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      remaining <= '0;
      xfer_cnt  <= '0;
    end else if (accept) begin
      remaining <= len;
      xfer_cnt  <= '0;
    end else if (state == XFER && abort) begin
      remaining <= '0;
    end else if (pop) begin
      remaining <= remaining - LSIZE'(1);
      xfer_cnt  <= xfer_cnt + LSIZE'(1);
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scenario bench for fifo_burst_reader with a
// queue FIFO model and an output scoreboard.
module tb_fifo_burst_reader;

  logic       rclk;
  logic       rrst_n;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] xfer_cnt;

  fifo_burst_reader_if #(.DSIZE(8)) bus ();

  fifo_burst_reader #(
    .DSIZE(8),
    .LSIZE(8)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .xfer_cnt(xfer_cnt)
  );

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int rinc_cnt = 0;
  int bad_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO model: pop on rinc, registered empty flag.
  always @(posedge rclk) begin
    if (bus.rinc && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    bus.rempty <= (fifo_q.size() == 0);
    bus.rdata  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Record stream handshakes and pulse activity.
  always @(negedge rclk) begin
    if (bus.dout_valid && bus.dout_ready)
      obs_q.push_back({bus.dout_last, bus.dout});
    if (done) done_cnt++;
    if (bus.rinc) rinc_cnt++;
    if (bus.rinc && (bus.rempty ||
        (bus.dout_valid && !bus.dout_ready)))
      bad_cnt++;
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d,
                           input logic l);
    fifo_q.push_back(d);
    exp_q.push_back({l, d});
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.rinc !== 1'b0) $display("FAIL rst_rinc got %b want 0", bus.rinc); else passes++;
    checks++; if (bus.dout_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.dout_valid); else passes++;
    checks++; if (bus.dout !== 8'h00) $display("FAIL rst_dout got %h want 00", bus.dout); else passes++;
    checks++; if (bus.dout_last !== 1'b0) $display("FAIL rst_last got %b want 0", bus.dout_last); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passes++;
    checks++; if (xfer_cnt !== 8'd0) $display("FAIL rst_cnt got %0d want 0", xfer_cnt); else passes++;
    #20 rrst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    int d0;
    bit got;
    logic [8:0] e;
    logic [8:0] o;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++)
      push_word(8'h10 + 8'(i), i == 3);
    tick();
    bus.dout_ready = 1'b1;
    start = 1'b1;
    len = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      checks++; if (bus.rinc !== 1'b1) $display("FAIL basic_rinc%0d got %b want 1", i, bus.rinc); else passes++;
    end
    @(negedge rclk);
    checks++; if (bus.rinc !== 1'b0) $display("FAIL basic_rinc_end got %b want 0", bus.rinc); else passes++;
    checks++; if (bus.dout !== 8'h13 || bus.dout_last !== 1'b1) $display("FAIL basic_lastword got %h/%b want 13/1", bus.dout, bus.dout_last); else passes++;
    @(negedge rclk);
    checks++; if (done !== 1'b1) $display("FAIL basic_done got %b want 1", done); else passes++;
    checks++; if (xfer_cnt !== 8'd4) $display("FAIL basic_cnt got %0d want 4", xfer_cnt); else passes++;
    got = 1'b1;
    @(negedge rclk);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done); else passes++;
    tick();
    checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_cnt got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_words got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (got && exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL basic_word got %h want %h", o, e); else passes++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    int d0;
    int b0;
    bit got;
    logic [8:0] e;
    logic [8:0] o;
    d0 = done_cnt;
    b0 = bad_cnt;
    push_word(8'h20, 1'b0);
    push_word(8'h21, 1'b0);
    push_word(8'h22, 1'b1);
    tick();
    bus.dout_ready = 1'b0;
    start = 1'b1;
    len = 8'd3;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (bus.dout_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (!got) $display("FAIL bp_first_valid got 0 want 1"); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.dout !== 8'h20 || bus.dout_valid !== 1'b1) $display("FAIL bp_hold%0d got %h/%b want 20/1", k, bus.dout, bus.dout_valid); else passes++;
      checks++; if (bus.rinc !== 1'b0) $display("FAIL bp_rinc%0d got %b want 0", k, bus.rinc); else passes++;
      @(negedge rclk);
    end
    @(posedge rclk);
    #1;
    bus.dout_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (!got) $display("FAIL bp_done got timeout want pulse"); else passes++;
    checks++; if (xfer_cnt !== 8'd3) $display("FAIL bp_cnt got %0d want 3", xfer_cnt); else passes++;
    tick();
    tick();
    checks++; if (done_cnt - d0 != 1) $display("FAIL bp_done_cnt got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (bad_cnt != b0) $display("FAIL bp_bad_pop got %0d want %0d", bad_cnt, b0); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL bp_words got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL bp_word got %h want %h", o, e); else passes++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_underflow();
    int b0;
    int busy_low;
    bit got;
    logic [8:0] e;
    logic [8:0] o;
    b0 = bad_cnt;
    busy_low = 0;
    start = 1'b1;
    len = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      if (!busy) busy_low++;
      checks++; if (bus.rinc !== 1'b0) $display("FAIL uf_rinc_empty%0d got %b want 0", i, bus.rinc); else passes++;
    end
    tick();
    push_word(8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      if (!busy) busy_low++;
    end
    tick();
    push_word(8'hBB, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) busy_low++;
    end
    checks++; if (!got) $display("FAIL uf_done got timeout want pulse"); else passes++;
    checks++; if (busy_low != 0) $display("FAIL uf_busy got %0d idle cycles want 0", busy_low); else passes++;
    checks++; if (xfer_cnt !== 8'd2) $display("FAIL uf_cnt got %0d want 2", xfer_cnt); else passes++;
    tick();
    checks++; if (bad_cnt != b0) $display("FAIL uf_bad_pop got %0d want %0d", bad_cnt, b0); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL uf_words got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL uf_word got %h want %h", o, e); else passes++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_abort();
    int r0;
    int d0;
    int n;
    bit got;
    logic [8:0] e;
    logic [8:0] o;
    for (int i = 0; i < 10; i++) begin
      fifo_q.push_back(8'h30 + 8'(i));
      if (i < 3) exp_q.push_back({1'b0, 8'h30 + 8'(i)});
    end
    tick();
    r0 = rinc_cnt;
    d0 = done_cnt;
    start = 1'b1;
    len = 8'd10;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge rclk);
      if (bus.rinc) n++;
    end
    @(posedge rclk);
    #1;
    abort = 1'b1;
    @(negedge rclk);
    checks++; if (bus.rinc !== 1'b0) $display("FAIL ab_rinc got %b want 0", bus.rinc); else passes++;
    tick();
    abort = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (!got) $display("FAIL ab_done got timeout want pulse"); else passes++;
    checks++; if (xfer_cnt !== 8'd3) $display("FAIL ab_cnt got %0d want 3", xfer_cnt); else passes++;
    tick();
    tick();
    checks++; if (rinc_cnt - r0 != 3) $display("FAIL ab_pops got %0d want 3", rinc_cnt - r0); else passes++;
    checks++; if (done_cnt - d0 != 1) $display("FAIL ab_done_cnt got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ab_words got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL ab_word got %h want %h", o, e); else passes++;
    end
    exp_q.delete();
    obs_q.delete();
    fifo_q.delete();
    tick();
    tick();
  endtask

  task automatic test_ignored();
    int r0;
    int d0;
    bit got;
    logic [8:0] e;
    logic [8:0] o;
    d0 = done_cnt;
    start = 1'b1;
    len = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      checks++; if (busy !== 1'b0) $display("FAIL ign_len0_busy%0d got %b want 0", i, busy); else passes++;
    end
    tick();
    checks++; if (done_cnt != d0) $display("FAIL ign_len0_done got %0d want %0d", done_cnt, d0); else passes++;
    checks++; if (xfer_cnt !== 8'd3) $display("FAIL ign_len0_cnt got %0d want 3", xfer_cnt); else passes++;
    r0 = rinc_cnt;
    start = 1'b1;
    len = 8'd2;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    len = 8'd5;
    tick();
    start = 1'b0;
    len = 8'd0;
    checks++; if (xfer_cnt !== 8'd0) $display("FAIL ign_busy_start_cnt got %0d want 0", xfer_cnt); else passes++;
    push_word(8'h40, 1'b0);
    push_word(8'h41, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (!got) $display("FAIL ign_done got timeout want pulse"); else passes++;
    checks++; if (xfer_cnt !== 8'd2) $display("FAIL ign_cnt got %0d want 2", xfer_cnt); else passes++;
    tick();
    checks++; if (rinc_cnt - r0 != 2) $display("FAIL ign_pops got %0d want 2", rinc_cnt - r0); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ign_words got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL ign_word got %h want %h", o, e); else passes++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    int n;
    bit got;
    logic [8:0] e;
    logic [8:0] o;
    for (int i = 0; i < 8; i++)
      fifo_q.push_back(8'h50 + 8'(i));
    tick();
    start = 1'b1;
    len = 8'd8;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge rclk);
      if (bus.rinc) n++;
    end
    #2;
    rrst_n = 1'b0;
    #1;
    checks++; if (bus.rinc !== 1'b0) $display("FAIL ar_rinc got %b want 0", bus.rinc); else passes++;
    checks++; if (bus.dout_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", bus.dout_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ar_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL ar_done got %b want 0", done); else passes++;
    checks++; if (xfer_cnt !== 8'd0) $display("FAIL ar_cnt got %0d want 0", xfer_cnt); else passes++;
    fifo_q.delete();
    @(negedge rclk);
    #2;
    rrst_n = 1'b1;
    tick();
    tick();
    exp_q.delete();
    obs_q.delete();
    push_word(8'h60, 1'b0);
    push_word(8'h61, 1'b1);
    tick();
    start = 1'b1;
    len = 8'd2;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (!got) $display("FAIL ar_done_after got timeout want pulse"); else passes++;
    checks++; if (xfer_cnt !== 8'd2) $display("FAIL ar_cnt_after got %0d want 2", xfer_cnt); else passes++;
    tick();
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ar_words got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL ar_word got %h want %h", o, e); else passes++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rrst_n = 1'b0;
    start = 1'b0;
    len = 8'd0;
    abort = 1'b0;
    bus.dout_ready = 1'b1;
    bus.rempty = 1'b1;
    bus.rdata = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_abort();
    test_ignored();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
